// File: rtl/pico_ctrl_if.sv
// Bus between the pico_ctrl fetch/decode stage, its program memory and the accumulator ALU.
// master = controller side (drives PC and decoded controls), slave = memory/ALU/board side.
interface pico_ctrl_if #(
  parameter int PW = 8,
  parameter int IW = 16
);
  logic [IW-1:0] instr;
  logic [7:0]    acc;
  logic          btn;
  logic [PW-1:0] pc;
  logic [7:0]    imm;
  logic [3:0]    reg_addr;
  logic          reg_we;
  logic          we;
  logic          sel_imm;
  logic          sel_sw;
  logic          sel_reg_data;
  logic          use_mul;
  logic          use_acc;
  logic          waiting;

  modport master (
    input  instr, acc, btn,
    output pc, imm, reg_addr, reg_we, we, sel_imm, sel_sw, sel_reg_data,
           use_mul, use_acc, waiting
  );

  modport slave (
    output instr, acc, btn,
    input  pc, imm, reg_addr, reg_we, we, sel_imm, sel_sw, sel_reg_data,
           use_mul, use_acc, waiting
  );
endinterface

// File: rtl/pico_ctrl.sv
// picoMips fetch/decode/control: PC, instruction decode and push-button WAIT handshake.
// Define PICO_CTRL_BRANCH_EN to build the JMP/BZ branch logic; otherwise opcodes 8/9 act as NOP.
module pico_ctrl #(
  parameter int PW = 8,
  parameter int IW = 16
) (
  input logic       clk,
  input logic       rst,
  pico_ctrl_if.master bus
);

  localparam logic [1:0] RUN          = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LDSW = 4'd3;
  localparam logic [3:0] OP_ADDR = 4'd4;
  localparam logic [3:0] OP_MULI = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_WAIT = 4'd7;
`ifdef PICO_CTRL_BRANCH_EN
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BZ   = 4'd9;
`endif

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_next;
  logic [PW-1:0] pc_inc;
  logic          b1;
  logic          b2;
  logic          b3;
  logic          rise;
  logic [3:0]    opcode;
  logic          in_run;
  logic          dec_we;
  logic          dec_reg_we;
  logic          dec_sel_imm;
  logic          dec_sel_sw;
  logic          dec_sel_reg_data;
  logic          dec_use_mul;
  logic          dec_use_acc;

  assign opcode = bus.instr[IW-1 -: 4];
  assign pc_inc = pc + PW'(1);
  assign rise   = b2 & ~b3;
  assign in_run = (state == RUN);

`ifdef PICO_CTRL_BRANCH_EN
  logic [PW-1:0] target;
  if (PW > 8) begin : g_target_wide
    assign target = {{(PW-8){1'b0}}, bus.instr[7:0]};
  end else begin : g_target_narrow
    assign target = bus.instr[PW-1:0];
  end
`else
  logic unused_acc;
  assign unused_acc = ^{1'b0, bus.acc};
`endif

  // b3 trails b2 so a button already held when WAIT is entered cannot count as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1 <= 1'b0;
      b2 <= 1'b0;
      b3 <= 1'b0;
    end else begin
      b1 <= bus.btn;
      b2 <= b1;
      b3 <= b2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      RUN: begin
        case (opcode)
          OP_WAIT: state_next = WAIT_PRESS;
`ifdef PICO_CTRL_BRANCH_EN
          OP_JMP:  pc_next = target;
          OP_BZ:   pc_next = (bus.acc == 8'd0) ? target : pc_inc;
`endif
          default: pc_next = pc_inc;
        endcase
      end
      WAIT_PRESS: begin
        if (rise) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!b2) begin
          state_next = RUN;
          pc_next    = pc_inc;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    dec_we           = 1'b0;
    dec_reg_we       = 1'b0;
    dec_sel_imm      = 1'b0;
    dec_sel_sw       = 1'b0;
    dec_sel_reg_data = 1'b0;
    dec_use_mul      = 1'b0;
    dec_use_acc      = 1'b0;
    case (opcode)
      OP_LDI: begin
        dec_sel_imm = 1'b1;
        dec_we      = 1'b1;
      end
      OP_ADDI: begin
        dec_sel_imm = 1'b1;
        dec_use_acc = 1'b1;
        dec_we      = 1'b1;
      end
      OP_LDSW: begin
        dec_sel_sw = 1'b1;
        dec_we     = 1'b1;
      end
      OP_ADDR: begin
        dec_sel_reg_data = 1'b1;
        dec_use_acc      = 1'b1;
        dec_we           = 1'b1;
      end
      OP_MULI: begin
        dec_use_mul = 1'b1;
        dec_use_acc = 1'b1;
        dec_we      = 1'b1;
      end
      OP_ST:   dec_reg_we = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are the only outputs that can corrupt state, so they alone are gated.
  assign bus.we           = dec_we & in_run & ~rst;
  assign bus.reg_we       = dec_reg_we & in_run & ~rst;
  assign bus.sel_imm      = dec_sel_imm;
  assign bus.sel_sw       = dec_sel_sw;
  assign bus.sel_reg_data = dec_sel_reg_data;
  assign bus.use_mul      = dec_use_mul;
  assign bus.use_acc      = dec_use_acc;
  assign bus.waiting      = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign bus.pc           = pc;
  assign bus.imm          = bus.instr[7:0];
  assign bus.reg_addr     = bus.instr[11:8];

endmodule

// File: tb/tb_pico_ctrl.sv
// Self-checking bench for pico_ctrl: directed program fragments, WAIT handshake,
// asynchronous reset, branches (when PICO_CTRL_BRANCH_EN is defined) and random instructions.
module tb_pico_ctrl;

  localparam int PW = 8;
  localparam int IW = 16;
`ifdef PICO_CTRL_BRANCH_EN
  localparam bit BRANCH = 1'b1;
`else
  localparam bit BRANCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  pico_ctrl_if #(.PW(PW), .IW(IW)) bus ();

  pico_ctrl #(.PW(PW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pc;
  logic [6:0] ctl_table [16];

  // Control bundle order: {we, reg_we, sel_imm, sel_sw, sel_reg_data, use_mul, use_acc}
  function automatic logic [6:0] ctlObserved();
    return {bus.we, bus.reg_we, bus.sel_imm, bus.sel_sw, bus.sel_reg_data,
            bus.use_mul, bus.use_acc};
  endfunction

  function automatic logic [7:0] expectedNextPc(logic [15:0] instr, logic [7:0] acc,
                                                logic [7:0] pc);
    logic [3:0] op;
    op = instr[15:12];
    if (BRANCH && op == 4'd8) return instr[7:0];
    if (BRANCH && op == 4'd9 && acc == 8'd0) return instr[7:0];
    return 8'(pc + 8'd1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one RUN-state instruction, checks its decode, then checks the PC after the edge.
  task automatic applyStimulus(input logic [15:0] instr, input logic [7:0] acc,
                               input string tag);
    bus.instr = instr;
    bus.acc   = acc;
    #2;
    checkOutput({tag, ".pc_before"}, 32'(bus.pc), 32'(model_pc));
    checkOutput({tag, ".ctl"}, 32'(ctlObserved()), 32'(ctl_table[instr[15:12]]));
    checkOutput({tag, ".imm"}, 32'(bus.imm), 32'(instr[7:0]));
    checkOutput({tag, ".reg_addr"}, 32'(bus.reg_addr), 32'(instr[11:8]));
    checkOutput({tag, ".waiting"}, 32'(bus.waiting), 32'(0));
    model_pc = expectedNextPc(instr, acc, model_pc);
    tick();
    checkOutput({tag, ".pc_after"}, 32'(bus.pc), 32'(model_pc));
  endtask

  initial begin
    logic [7:0]  p;
    logic [15:0] r_instr;
    logic [3:0]  r_op;
    logic [7:0]  r_acc;
    int          n;

    for (int i = 0; i < 16; i++) ctl_table[i] = 7'b0;
    ctl_table[1] = 7'b1010000;
    ctl_table[2] = 7'b1010001;
    ctl_table[3] = 7'b1001000;
    ctl_table[4] = 7'b1000101;
    ctl_table[5] = 7'b1000011;
    ctl_table[6] = 7'b0100000;

    rst       = 1'b1;
    bus.btn   = 1'b0;
    bus.acc   = 8'd0;
    bus.instr = 16'h1005;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.we_forced", 32'(bus.we), 32'(0));
    checkOutput("reset.pc", 32'(bus.pc), 32'(0));
    bus.instr = 16'h6200;
    #1;
    checkOutput("reset.reg_we_forced", 32'(bus.reg_we), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    checkOutput("release.pc", 32'(bus.pc), 32'(0));
    checkOutput("release.waiting", 32'(bus.waiting), 32'(0));
    model_pc = 8'd0;

    applyStimulus(16'h1005, 8'd0, "ldi5");
    applyStimulus(16'h1003, 8'd0, "ldi3");
    applyStimulus(16'h2004, 8'd3, "addi4");
    applyStimulus(16'h6200, 8'd7, "st_r2");

    // WAIT entered with the button already held: must not count as a press.
    bus.btn = 1'b1;
    repeat (3) applyStimulus(16'h0000, 8'd0, "pre_wait_nop");
    p = model_pc;
    bus.instr = 16'h7000;
    #2;
    checkOutput("wait.entry_ctl", 32'(ctlObserved()), 32'(ctl_table[7]));
    tick();
    checkOutput("wait.entered", 32'(bus.waiting), 32'(1));
    checkOutput("wait.pc_hold", 32'(bus.pc), 32'(p));
    bus.instr = 16'h1005;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("wait.held_btn_waiting", 32'(bus.waiting), 32'(1));
      checkOutput("wait.held_btn_pc", 32'(bus.pc), 32'(p));
      checkOutput("wait.we_gated", 32'(bus.we), 32'(0));
    end
    bus.btn = 1'b0;
    repeat (4) tick();
    checkOutput("wait.btn_low_waiting", 32'(bus.waiting), 32'(1));
    bus.btn   = 1'b1;
    bus.instr = 16'h6200;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("wait.press_waiting", 32'(bus.waiting), 32'(1));
      checkOutput("wait.reg_we_gated", 32'(bus.reg_we), 32'(0));
      checkOutput("wait.press_pc", 32'(bus.pc), 32'(p));
    end
    bus.btn   = 1'b0;
    bus.instr = 16'h0000;
    n = 0;
    while (bus.waiting && n < 10) begin
      tick();
      n++;
    end
    checkOutput("wait.exit", 32'(bus.waiting), 32'(0));
    checkOutput("wait.exit_latency_ok", 32'(n >= 2 && n <= 4), 32'(1));
    model_pc = 8'(p + 8'd1);
    checkOutput("wait.exit_pc", 32'(bus.pc), 32'(model_pc));

    applyStimulus(16'h9020, 8'h00, "bz_taken");
    applyStimulus(16'h9020, 8'h01, "bz_not_taken");
    applyStimulus(16'h8020, 8'h00, "op8");
    applyStimulus(16'h80FF, 8'h55, "jmp_ff");
    applyStimulus(16'h0000, 8'h00, "nop_after_jmp");

    for (int i = 0; i < 300; i++) begin
      r_op = 4'($urandom_range(0, 15));
      if (r_op == 4'd7) r_op = 4'd0;
      r_instr = {r_op, 4'($urandom), 8'($urandom)};
      r_acc   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus(r_instr, r_acc, "random");
    end

    n = 0;
    while (model_pc != 8'hFF && n < 300) begin
      applyStimulus(16'h0000, 8'd0, "to_top");
      n++;
    end
    applyStimulus(16'h0000, 8'd0, "wrap");
    checkOutput("wrap.pc_zero", 32'(bus.pc), 32'(0));

    // Asynchronous reset while parked in WAIT_RELEASE.
    bus.btn   = 1'b0;
    bus.instr = 16'h7000;
    tick();
    checkOutput("rst_wait.entered", 32'(bus.waiting), 32'(1));
    bus.btn = 1'b1;
    repeat (5) tick();
    checkOutput("rst_wait.still_waiting", 32'(bus.waiting), 32'(1));
    bus.instr = 16'h6200;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_wait.pc", 32'(bus.pc), 32'(0));
    checkOutput("rst_wait.waiting", 32'(bus.waiting), 32'(0));
    checkOutput("rst_wait.reg_we", 32'(bus.reg_we), 32'(0));
    bus.btn   = 1'b0;
    bus.instr = 16'h0000;
    tick();
    rst = 1'b0;
    model_pc = 8'd0;
    applyStimulus(16'h1042, 8'd0, "post_reset_ldi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_ctrl.md
Name: pico_ctrl

Overview:
- Fetch/decode/control stage sitting directly upstream of the picoMips accumulator ALU.
- Owns the program counter and decodes each instruction word from program memory into the ALU's select, enable and immediate signals, plus the register-file write strobe.
- Sequences branches and a push-button WAIT handshake, so the ALU sees one executed instruction per cycle except while the program is parked on the button.

Parameters:
PW, 8, program counter width; program memory depth 2**PW.
IW, 16, instruction width; fixed layout opcode[15:12], rd[11:8], imm[7:0].

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  one clock; reset is asynchronous and active-high.
Instr  in  IW  instruction at PC; combinational program-memory read.
ACC  in  8  current accumulator from the ALU, used for BZ.
Btn  in  1  raw asynchronous push-button, active-high.
PC  out  PW  program counter, registered.
Imm  out  8  Instr[7:0], passed straight to the ALU.
RegAddr  out  4  Instr[11:8]; register-file read/write address.
RegWE  out  1  register-file write strobe; writes ACC to RegAddr.
WE  out  1  ALU accumulator write enable.
SelImm  out  1  ALU operand select: immediate.
SelSW  out  1  ALU operand select: switches.
SelRegData  out  1  ALU operand select: register data.
UseMul  out  1  ALU multiply enable.
UseACC  out  1  ALU uses ACC as an operand.
Waiting  out  1  high while parked in a WAIT state.

Behaviour:
- Reset values:
  - PC=0; FSM=RUN; button synchroniser flops=0.
  - While Reset is high, WE and RegWE are forced to 0.
  - Reset mid-WAIT returns the FSM to RUN with PC=0.
- Decode is combinational from Instr and FSM state, so the ALU captures its result at the same edge that advances PC. Single-cycle latency per instruction.
- Opcodes; all unlisted outputs are 0:
  - 0 NOP: no outputs asserted.
  - 1 LDI: SelImm, WE.
  - 2 ADDI: SelImm, UseACC, WE.
  - 3 LDSW: SelSW, WE.
  - 4 ADDR: SelRegData, UseACC, WE.
  - 5 MULI: UseMul, UseACC, WE.
  - 6 ST: RegWE.
  - 7 WAIT: no enables asserted.
  - 8 JMP, 9 BZ: see Optional Feature.
  - 10–15: decoded as NOP.
- In RUN, non-branch opcodes advance PC by 1. PC wraps from 2**PW-1 to 0.
- Button handling:
  - 2-flop synchroniser b1 -> b2, plus a third flop b3.
  - Rise = b2 & ~b3.
- FSM:
  - RUN: opcode WAIT -> WAIT_PRESS; PC holds.
  - WAIT_PRESS: Rise -> WAIT_RELEASE. A button already held on entry does not satisfy; a fresh rising edge is required.
  - WAIT_RELEASE: b2==0 -> RUN, and PC+1 on the same edge.
- In both WAIT states:
  - Waiting=1.
  - WE=RegWE=0 regardless of Instr.
  - PC holds.
  - The ALU is frozen.
- Btn glitch shorter than one clock may be missed; this is acceptable.

Optional Feature:
Macro PICO_CTRL_BRANCH_EN.
- Defined:
  - JMP: PC <= Imm[PW-1:0] (zero-extended if PW>8); no enables.
  - BZ: if ACC==8'd0 then PC <= Imm[PW-1:0], else PC+1.
  - The branch takes effect on the executing edge; no delay slot.
  - JMP to its own address is a legal halt loop.
- Undefined:
  - Opcodes 8 and 9 decode as NOP and PC+1.
  - No branch logic is synthesised.

Test Plan:
- Reset release -> PC=0, WE=0, Waiting=0. Instr=16'h1005 (LDI 5) -> WE=1, SelImm=1, Imm=8'h05; PC=1 after the edge.
- Sequence LDI 3, ADDI 4, ST r2 -> ADDI cycle asserts UseACC+SelImm+WE. ST cycle asserts RegWE=1, RegAddr=2, WE=0. PC steps 0,1,2,3.
- WAIT at PC=4, Btn held high before entry -> stays in WAIT_PRESS, Waiting=1, PC=4. Btn low, then high for 5 cycles, then low -> RUN, PC=5 about 2 cycles after the fall.
- Reset asserted asynchronously while in WAIT_RELEASE -> immediate PC=0, Waiting=0, RegWE=0.
- With PICO_CTRL_BRANCH_EN:
  - BZ 8'h20 with ACC=0 -> PC=8'h20.
  - BZ with ACC=8'h01 -> PC+1.
  - JMP 8'hFF, then NOP -> PC=8'hFF, then wraps to 0.
- Without the macro: Instr=16'h8020 -> treated as NOP, PC+1, no enables asserted.
